// File: rtl/triad_decoder_if.sv
// Triad decoder bus: serial triad inputs, control, decoded half-strip hits and monitor count.
interface triad_decoder_if #(
    parameter int unsigned NCH       = 6,
    parameter int unsigned PERSIST_W = 4,
    parameter int unsigned CNT_W     = 16
) ();
    logic [NCH-1:0]       triad_in;
    logic [PERSIST_W-1:0] persist;
    logic                 enable;
    logic                 cnt_clear;
    logic [4*NCH-1:0]     hs_out;
    logic [NCH-1:0]       ch_busy;
    logic [CNT_W-1:0]     triad_count;

    // Upstream side: drives triads and control, observes hits
    modport master (
        output triad_in, persist, enable, cnt_clear,
        input  hs_out, ch_busy, triad_count
    );

    // Decoder side
    modport slave (
        input  triad_in, persist, enable, cnt_clear,
        output hs_out, ch_busy, triad_count
    );
endinterface

// File: rtl/triad_decoder.sv
// Triad decoder: deserializes 3-bit triads per channel into one-hot half-strip hits,
// stretches each hit for a programmable window, and counts decoded triads (saturating).
module triad_decoder #(
    parameter int unsigned NCH       = 6,
    parameter int unsigned PERSIST_W = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    triad_decoder_if.slave   bus
);
    localparam int unsigned HS_W      = 4 * NCH;
    localparam int unsigned SUM_W     = $clog2(NCH + 1);
    localparam int unsigned CNT_SUM_W = CNT_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BIT1 = 2'd1,
        BIT2 = 2'd2
    } state_t;

    state_t               state [NCH];
    logic [NCH-1:0]       dsel;
    logic [NCH-1:0]       busy;
    logic [HS_W-1:0]      dec_hs_c;
    logic [SUM_W-1:0]     n_dec_c;
    logic [CNT_SUM_W-1:0] cnt_sum_c;
    logic [PERSIST_W-1:0] hold [HS_W];
    logic [HS_W-1:0]      lit;
    logic [CNT_W-1:0]     count;

    // Per-channel triad FSM: start bit, distrip select, side; decode issued in BIT2
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                state[c] <= IDLE;
            end
            dsel <= '0;
        end else begin
            for (int unsigned c = 0; c < NCH; c++) begin
                case (state[c])
                    IDLE: begin
                        if (bus.triad_in[c] && bus.enable) begin
                            state[c] <= BIT1;
                        end
                    end
                    BIT1: begin
                        dsel[c]  <= bus.triad_in[c];
                        state[c] <= BIT2;
                    end
                    BIT2:    state[c] <= IDLE;
                    default: state[c] <= IDLE;
                endcase
            end
        end
    end

    // Decode strobes: half-strip k = {d, ~h}, left side maps to the lower index
    always_comb begin
        dec_hs_c = '0;
        n_dec_c  = '0;
        busy     = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            busy[c] = (state[c] != IDLE);
            if (state[c] == BIT2) begin
                dec_hs_c[4*c +: 4] = 4'b0001 << {dsel[c], ~bus.triad_in[c]};
                n_dec_c            = n_dec_c + SUM_W'(1);
            end
        end
        cnt_sum_c = {1'b0, count} + CNT_SUM_W'(n_dec_c);
    end

    // Persistence: a decode (re)loads the window, so a retrigger extends it without a gap
    always_ff @(posedge clock) begin
        if (reset) begin
            lit <= '0;
            for (int unsigned i = 0; i < HS_W; i++) begin
                hold[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < HS_W; i++) begin
                if (dec_hs_c[i]) begin
                    lit[i]  <= 1'b1;
                    hold[i] <= bus.persist;
                end else if (lit[i]) begin
                    if (hold[i] == '0) begin
                        lit[i] <= 1'b0;
                    end else begin
                        hold[i] <= hold[i] - PERSIST_W'(1);
                    end
                end
            end
        end
    end

    // Saturating triad counter; clear wins over same-cycle increments
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (bus.cnt_clear) begin
            count <= '0;
        end else if (n_dec_c != '0) begin
            count <= cnt_sum_c[CNT_W] ? '1 : cnt_sum_c[CNT_W-1:0];
        end
    end

    assign bus.hs_out      = lit;
    assign bus.ch_busy     = busy;
    assign bus.triad_count = count;
endmodule

// File: tb/tb_triad_decoder.sv
// Scoreboard bench for triad_decoder: directed triads push per-cycle expectations,
// a negedge monitor pops and compares them against hs_out, ch_busy and triad_count.
module tb_triad_decoder;
    typedef struct {
        int          cyc;
        logic [23:0] hs;
        logic [5:0]  busy;
        logic [15:0] cnt;
        string       name;
    } exp_t;

    logic clock;
    logic reset;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   s;
    exp_t sb [$];
    exp_t mon_e;

    triad_decoder_if #(.NCH(6), .PERSIST_W(4), .CNT_W(16)) bus ();

    triad_decoder #(.NCH(6), .PERSIST_W(4), .CNT_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic expect_at(input int c, input logic [23:0] hs, input logic [5:0] busy,
                             input logic [15:0] cnt, input string nm);
        exp_t e;
        e.cyc = c; e.hs = hs; e.busy = busy; e.cnt = cnt; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic step(input logic [5:0] t);
        bus.triad_in = t;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(6'b0);
    endtask

    // Monitor: compare every expectation due in the current cycle
    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            n_checks++;
            if (mon_e.cyc != cyc || bus.hs_out !== mon_e.hs || bus.ch_busy !== mon_e.busy ||
                bus.triad_count !== mon_e.cnt) begin
                $display("FAIL %s cyc=%0d (due %0d): hs=%h busy=%b cnt=%h, required hs=%h busy=%b cnt=%h",
                         mon_e.name, cyc, mon_e.cyc, bus.hs_out, bus.ch_busy, bus.triad_count,
                         mon_e.hs, mon_e.busy, mon_e.cnt);
            end else begin
                n_pass++;
            end
        end
    end

    initial begin
        reset         = 1'b1;
        bus.triad_in  = '0;
        bus.persist   = '0;
        bus.enable    = 1'b1;
        bus.cnt_clear = 1'b0;
        expect_at(1, 24'h0, 6'h0, 16'd0, "reset1");
        expect_at(2, 24'h0, 6'h0, 16'd0, "reset2");
        idle(2);
        reset = 1'b0;
        idle(1);

        // 1: ch0 triad 1,0,0 persist=0 -> hs[1] one cycle
        bus.persist = 4'd0;
        s = cyc;
        for (int i = 0; i < 6; i++)
            expect_at(s + i, (i == 3) ? 24'h000002 : 24'h0, (i == 1 || i == 2) ? 6'b000001 : 6'b0,
                      (i >= 3) ? 16'd1 : 16'd0, "t1_ch0");
        step(6'b000001); step(6'b0); step(6'b0);
        idle(4);

        // 2: ch2 triad 1,1,1 persist=5 -> hs[10] six cycles; persist change mid-window ignored
        bus.persist = 4'd5;
        s = cyc;
        for (int i = 0; i < 11; i++)
            expect_at(s + i, (i >= 3 && i <= 8) ? 24'h000400 : 24'h0, (i == 1 || i == 2) ? 6'b000100 : 6'b0,
                      (i >= 3) ? 16'd2 : 16'd1, "t2_ch2");
        step(6'b000100); step(6'b000100); step(6'b000100);
        bus.persist = 4'd0;
        idle(9);

        // 3: ch1 back-to-back 1,0,1 persist=3 -> hs[4] seven cycles continuous
        bus.persist = 4'd3;
        s = cyc;
        for (int i = 0; i < 13; i++)
            expect_at(s + i, (i >= 3 && i <= 9) ? 24'h000010 : 24'h0,
                      (i == 1 || i == 2 || i == 4 || i == 5) ? 6'b000010 : 6'b0,
                      (i >= 6) ? 16'd4 : ((i >= 3) ? 16'd3 : 16'd2), "t3_retrig");
        step(6'b000010); step(6'b0); step(6'b000010);
        step(6'b000010); step(6'b0); step(6'b000010);
        idle(8);

        // 4: clear, then all channels every 3 cycles up to saturation
        s = cyc;
        expect_at(s + 1, 24'h0, 6'h0, 16'd0, "t4_clear");
        bus.cnt_clear = 1'b1;
        step(6'b0);
        bus.cnt_clear = 1'b0;
        bus.persist = 4'd0;
        repeat (10922) begin
            step(6'h3F); step(6'b0); step(6'b0);
        end
        idle(2);
        expect_at(cyc, 24'h0, 6'h0, 16'd65532, "t4_preset");
        idle(1);
        s = cyc;
        expect_at(s + 1, 24'h0, 6'h3F, 16'd65532, "t4_busy_all");
        expect_at(s + 3, 24'h222222, 6'h0, 16'hFFFF, "t4_saturate");
        expect_at(s + 6, 24'h222222, 6'h0, 16'hFFFF, "t4_no_wrap");
        expect_at(s + 7, 24'h0, 6'h0, 16'hFFFF, "t4_hold");
        step(6'h3F); step(6'b0); step(6'b0);
        step(6'h3F); step(6'b0); step(6'b0);
        idle(2);
        s = cyc;
        expect_at(s + 3, 24'h222222, 6'h0, 16'd0, "t4_clear_prio");
        expect_at(s + 4, 24'h0, 6'h0, 16'd0, "t4_after_clear");
        step(6'h3F); step(6'b0);
        bus.cnt_clear = 1'b1;
        step(6'b0);
        bus.cnt_clear = 1'b0;
        idle(3);

        // 5: reset during BIT1 of ch3 -> partial triad discarded
        bus.persist = 4'd2;
        s = cyc;
        for (int i = 0; i < 8; i++)
            expect_at(s + i, 24'h0, (i == 1) ? 6'b001000 : 6'b0, 16'd0, "t5_reset_mid");
        step(6'b001000);
        reset = 1'b1;
        step(6'b001000);
        reset = 1'b0;
        idle(6);

        // 6a: enable=0 -> start bit ignored
        bus.enable = 1'b0;
        bus.persist = 4'd0;
        s = cyc;
        for (int i = 0; i < 7; i++)
            expect_at(s + i, 24'h0, 6'b0, 16'd0, "t6_disabled");
        step(6'b010000);
        idle(6);

        // 6b: enable falls in BIT1 -> triad 1,1,0 on ch4 still decodes to hs[19]
        bus.enable = 1'b1;
        s = cyc;
        for (int i = 0; i < 7; i++)
            expect_at(s + i, (i == 3) ? 24'h080000 : 24'h0, (i == 1 || i == 2) ? 6'b010000 : 6'b0,
                      (i >= 3) ? 16'd1 : 16'd0, "t6_en_fall");
        step(6'b010000);
        bus.enable = 1'b0;
        step(6'b010000);
        step(6'b0);
        idle(4);
        bus.enable = 1'b1;

        // Drain with a bounded wait
        for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1);
        if (sb.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations still pending, required 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
